// File: rtl/regfile_dump.sv
// Debug read-out engine: walks x0..x31 through a dedicated register-file read port
// and streams each value over valid/ready. Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word.
module regfile_dump #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [4:0]        rf_rs,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PTR_W = 6;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NREGS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [PTR_W-1:0]   out_idx_q, out_idx_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic               handshake_c;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]  csum_q, csum_d;
`endif

  assign handshake_c = out_valid_q & out_ready;

  // Next-state: one read per accepted word, output register acts as the single pipeline stage
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (start) begin
          out_data_d  = rf_rdata;
          out_idx_d   = '0;
          out_valid_d = 1'b1;
          ptr_d       = PTR_W'(1);
          state_d     = RUN;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          // Zero seed XOR x0 folds directly into the capture cycle
          csum_d      = rf_rdata;
`endif
        end
      end
      RUN: begin
        if (handshake_c) begin
          if (ptr_q < LAST_PTR) begin
            out_data_d = rf_rdata;
            out_idx_d  = ptr_q;
            ptr_d      = ptr_q + PTR_W'(1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_d     = csum_q ^ rf_rdata;
`endif
          end
`ifdef REGFILE_DUMP_CHECKSUM_EN
          else if (out_idx_q != LAST_PTR) begin
            out_data_d = csum_q;
            out_idx_d  = LAST_PTR;
          end
`endif
          else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            ptr_d       = '0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rf_rs     = ptr_q[4:0];
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed and throttled checks of regfile_dump against a behavioural register file.
// Expectations follow REGFILE_DUMP_CHECKSUM_EN when defined for the build.
module tb_regfile_dump;

  localparam int unsigned DATA_W = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int NW = 33;
`else
  localparam int NW = 32;
`endif

  logic              clk;
  logic              resetn;
  logic              start;
  logic [4:0]        rf_rs;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [5:0]        out_idx;
  logic              busy;
  logic              done;

  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  regfile_dump #(.DATA_W(DATA_W), .NREGS(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .rf_rs(rf_rs), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  assign rf_rdata = rf[rf_rs];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (resetn && done) done_cnt++;

  typedef struct {
    int          stall_idx;
    int          stall_len;
    int          wr_at;
    int          wr_reg;
    logic [31:0] wr_val;
    int          start_at;
    bit          start_on_done;
    int          exp_done_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one dump from a start pulse; called at a negedge, returns at a negedge
  task automatic run_dump(input vec_t v, input bit rnd);
    int cyc, words, stalled;
    logic [31:0] csum, expd;
    bit wrote, finished;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; words = 0; stalled = 0; csum = '0; wrote = 0; finished = 0;
    while (!finished && cyc < 400) begin
      if (done) begin
        chk("word_count", 32'(words), 32'(NW));
        if (v.exp_done_cyc != 0) chk("done_cycle", 32'(cyc), 32'(v.exp_done_cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("valid_at_done", 32'(out_valid), 32'd0);
        finished = 1;
      end else begin
        chk("busy", 32'(busy), 32'd1);
        chk("valid", 32'(out_valid), 32'd1);
        chk("idx", 32'(out_idx), 32'(words));
        if (words < 32) expd = rf[words];
        else expd = csum;
        chk("data", out_data, expd);
        start = (words == v.start_at);
        if (!wrote && words == v.wr_at) begin
          rf[v.wr_reg] = v.wr_val;
          wrote = 1;
        end
        if (words == v.stall_idx && stalled < v.stall_len) begin
          out_ready = 1'b0;
          stalled++;
          chk("rf_rs_hold", 32'(rf_rs), 32'(words + 1));
        end else begin
          out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          csum = csum ^ expd;
          words++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) begin
      errors++;
      $display("FAIL dump_timeout: got no done after %0d cycles expected done", cyc);
      start = 1'b0;
    end else if (v.start_on_done) begin
      start = 1'b1;
    end else begin
      start = 1'b0;
      @(negedge clk);
      chk("done_pulse_width", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  vec_t vecs [5];
  vec_t plain;

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);

    vecs[0] = '{-1, 0, -1, 0, 32'h0, -1, 1'b0, NW + 1};
    vecs[1] = '{ 5, 3, -1, 0, 32'h0, -1, 1'b0, NW + 4};
    vecs[2] = '{-1, 0,  3, 10, 32'hDEAD_BEEF, -1, 1'b0, NW + 1};
    vecs[3] = '{-1, 0, -1, 0, 32'h0,  8, 1'b1, NW + 1};
    vecs[4] = '{-1, 0, -1, 0, 32'h0, -1, 1'b0, NW + 1};
    plain   = vecs[0];

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rf_rs", 32'(rf_rs), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) run_dump(vecs[k], 1'b0);
    chk("x10_written_value", rf[10], 32'hDEAD_BEEF);

    // Asynchronous reset while idx 17 is presented
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && out_idx != 6'd17; i++) @(negedge clk);
    chk("reach_idx17", 32'(out_idx), 32'd17);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rf_rs", 32'(rf_rs), 32'd0);
    @(negedge clk);
    chk("arst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    run_dump(plain, 1'b0);

    for (int d = 0; d < 100; d++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      plain.exp_done_cyc = 0;
      run_dump(plain, 1'b1);
    end

    @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'd106);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the core's 32 x 32-bit integer register file. It owns a dedicated register-file read port and, on a start pulse, walks x0..x31 in order. Each value is streamed out over a valid/ready interface tagged with its register index, so a debug/UART/trace bridge can pull a full architectural register snapshot without stalling the pipeline. It sits beside the register file on the debug side of the core.

## Interface
- `DATA_W`, 32: register width; also the width of the checksum word.
- `NREGS`, 32: number of registers walked, indices 0..NREGS-1; fixed at 32 for this core.
- `clk`  in  1: clock, rising-edge.
- `resetn`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begins a dump when sampled high while `busy`=0; ignored while `busy`=1.
- `rf_rs`  out  5: read address driven to the register-file debug read port.
- `rf_rdata`  in  DATA_W: combinational read data for `rf_rs`, valid in the same cycle.
- `out_valid`  out  1: `out_data`/`out_idx` hold a word.
- `out_ready`  in  1: consumer accepts the word when high together with `out_valid`.
- `out_data`  out  DATA_W: register value (or checksum).
- `out_idx`  out  6: 0..31 = register index; 32 = checksum word (macro-dependent).
- `busy`  out  1: a dump is in progress.
- `done`  out  1: one-cycle pulse after the final word is accepted.

## Operation
- State: `IDLE`, `RUN`. Registers: `ptr` (6 b, next index to read), `out_data`, `out_idx`, `out_valid`, `done`, optional `csum`.
- `rf_rs` = `ptr[4:0]`, driven combinationally in every state. `ptr` = 0 in `IDLE`.
- IDLE + `start`:
  - capture `rf_rdata` (x0) into `out_data`; `out_idx` = 0; `out_valid` = 1.
  - `ptr` = 1; go to `RUN`.
- RUN, handshake (`out_valid & out_ready`), `ptr` < 32:
  - capture `rf_rdata` at `rf_rs` = `ptr`; `out_idx` = `ptr`; `ptr` += 1; `out_valid` stays 1.
- RUN, no handshake: `out_data`, `out_idx`, `out_valid` hold unchanged. The source must not change a presented word.
- RUN, handshake with `ptr` = 32 (last word accepted):
  - `out_valid` = 0; `done` = 1 for the next cycle; go to `IDLE`.
- Snapshot semantics: each word is the register value in the cycle it is captured (start cycle or previous handshake cycle). The dump is not atomic; concurrent writeback is visible for later indices.
- x0 is read through the port like any other register. It is expected to be 0 but is not forced.
- `busy` = (state == `RUN`).
- `start` in the `done` cycle is accepted, because state is already `IDLE`.
- Reset (any time, including mid-dump) forces:
  - state `IDLE`, `ptr` = 0;
  - `out_valid`, `out_data`, `out_idx`, `done`, `csum` = 0;
  - no `done` pulse for the aborted dump.

## Timing
- `start` sampled at edge t → `out_valid` = 1 with x0 after edge t (cycle t+1).
- With `out_ready` held high: one word per cycle, x0..x31 in cycles t+1..t+32.
- `done` high and `busy` low in cycle t+33.
- Each `out_ready` low cycle delays all later words and `done` by one cycle.
- Read-to-output latency: one register stage, `rf_rdata` → `out_data`.

## Configuration
- `REGFILE_DUMP_CHECKSUM_EN` defined:
  - `csum` accumulates the XOR of every emitted register word, seeded 0 on `start`.
  - After x31 is accepted, one extra word is emitted: `out_data` = `csum`, `out_idx` = 32.
  - `done` pulses after that word is accepted. The dump is 33 words; `done` arrives at t+34 with `out_ready` high.
- Not defined:
  - no `csum` register; dump is exactly 32 words; `out_idx` never exceeds 31.

## Test plan
- Preload x_i = 0x1000_0000 + i (x0 = 0), `out_ready` = 1, pulse `start` → idx 0..31 with the matching data in 32 consecutive cycles, `done` 33 cycles after `start`. With the macro: extra word idx 32, data = XOR of all 32 values.
- Drop `out_ready` for 3 cycles while idx 5 (0x1000_0005) is presented → word held stable, `rf_rs` stays 6; stream resumes with idx 6; `done` delayed by 3 cycles.
- Write x10 = 0xDEAD_BEEF while idx 3 is presented → idx 10 outputs 0xDEAD_BEEF.
- Pulse `start` while `busy` → ignored, word order unchanged. Pulse `start` in the `done` cycle → new dump begins, x0 in the following cycle.
- Assert `resetn` low while idx 17 is presented → all outputs 0 asynchronously, no `done`. After release, `start` restarts the dump from idx 0.
- Random `out_ready` throttling (50%) over 100 dumps → scoreboard matches every index/value, and `done` pulses exactly once per dump.
